// File: rtl/kernel_sysid_checker.sv
// Purpose : Avalon-MM master that reads the system-ID peripheral (word 0 = ID, word 1 = build timestamp) and checks both words.
// Latency : launch -> done is 2 read transactions + 1 CHECK cycle + 1 DONE cycle; each read is bounded to TIMEOUT_CYCLES cycles.
// Backpress: avm_read/avm_address are held while avm_waitrequest=1; start is ignored (not queued) unless the FSM is IDLE.
//
// Ports:
//   clock, reset_n          system clock, synchronous active-low reset
//   start                   one-cycle launch pulse (ignored while busy or in the DONE cycle)
//   avm_address, avm_read   read command to the peripheral (address only meaningful with avm_read=1)
//   avm_waitrequest         slave stall
//   avm_readdata/_readdatavalid  read response
//   busy, done              check in progress / one-cycle completion pulse
//   id_ok, ts_ok            result of comparing the captured words to EXPECTED_ID / EXPECTED_TS
//   timeout_err             all retries timed out
//   id_word, ts_word        last captured words
//   retry_count             retries used in the current/last check

module kernel_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd2,
    parameter logic [31:0] EXPECTED_TS    = 32'd1504027687,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_word,
    output logic [31:0] ts_word,
    output logic [3:0]  retry_count
);

    // Last cycle index of a transaction: the counter starts at 0 on the
    // first cycle, so value TIMEOUT_CYCLES-1 marks the final allowed cycle.
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ID_REQ  = 3'd1,
        ID_WAIT = 3'd2,
        TS_REQ  = 3'd3,
        TS_WAIT = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] tmo_cnt_q;
    logic [3:0]  retry_q;
    logic        gap_q;
    logic        addr_q;
    logic        auto_q;
    logic        id_ok_q;
    logic        ts_ok_q;
    logic        tmo_err_q;
    logic [31:0] id_word_q;
    logic [31:0] ts_word_q;

    logic in_req;
    logic in_wait;
    logic read_c;
    logic accept;
    logic capture;
    logic tmo_hit;
    logic launch;
    logic abandon;
    logic retry_ok;
    logic enter_req;

    // ------------------------------------------------------------------
    // Datapath qualifiers
    // ------------------------------------------------------------------
    assign in_req  = (state_q == ID_REQ) || (state_q == TS_REQ);
    assign in_wait = (state_q == ID_WAIT) || (state_q == TS_WAIT);

    // gap_q keeps avm_read low for one cycle after an abandoned read so the
    // retried request is a distinct command on the bus.
    assign read_c  = in_req && !gap_q;
    assign accept  = read_c && !avm_waitrequest;
    assign capture = in_wait && avm_readdatavalid;

    // Only counted cycles can time out; the gap cycle is not part of any
    // transaction. A capture in the final cycle takes priority in the FSM.
    assign tmo_hit  = (read_c || in_wait) && (tmo_cnt_q == TMO_LAST);
    assign launch   = (state_q == IDLE) && (start || auto_q);
    assign retry_ok = (retry_q < RETRY_MAX);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        abandon = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = ID_REQ;
                end
            end
            ID_REQ: begin
                // An accept in the final cycle still abandons: no data has
                // been captured, and any late response lands outside a WAIT
                // state where it is ignored.
                if (tmo_hit) begin
                    abandon = 1'b1;
                end else if (accept) begin
                    state_d = ID_WAIT;
                end
            end
            ID_WAIT: begin
                if (capture) begin
                    state_d = TS_REQ;
                end else if (tmo_hit) begin
                    abandon = 1'b1;
                end
            end
            TS_REQ: begin
                if (tmo_hit) begin
                    abandon = 1'b1;
                end else if (accept) begin
                    state_d = TS_WAIT;
                end
            end
            TS_WAIT: begin
                if (capture) begin
                    state_d = CHECK;
                end else if (tmo_hit) begin
                    abandon = 1'b1;
                end
            end
            CHECK: begin
                state_d = DONE;
            end
            DONE: begin
                // start in this cycle is deliberately dropped.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any abandoned read restarts the whole sequence from the ID word.
        if (abandon) begin
            state_d = retry_ok ? ID_REQ : DONE;
        end
    end

    // A REQ state is (re)entered on a state change or on a retry of ID_REQ
    // from within ID_REQ itself.
    assign enter_req = ((state_d == ID_REQ) || (state_d == TS_REQ)) &&
                       ((state_d != state_q) || abandon);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tmo_cnt_q <= 16'd0;
            retry_q   <= 4'd0;
            gap_q     <= 1'b0;
            addr_q    <= 1'b0;
            auto_q    <= AUTO_START;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            tmo_err_q <= 1'b0;
            id_word_q <= 32'd0;
            ts_word_q <= 32'd0;
        end else begin
            state_q <= state_d;
            gap_q   <= abandon && retry_ok;

            // Timeout counter
            if (enter_req) begin
                tmo_cnt_q <= 16'd0;
            end else if (read_c || in_wait) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end

            // Address register: only changes when a new REQ state is
            // entered, so it holds its value between commands.
            if (state_d == ID_REQ) begin
                addr_q <= 1'b0;
            end else if (state_d == TS_REQ) begin
                addr_q <= 1'b1;
            end

            if (launch) begin
                auto_q    <= 1'b0;
                id_ok_q   <= 1'b0;
                ts_ok_q   <= 1'b0;
                tmo_err_q <= 1'b0;
                retry_q   <= 4'd0;
            end

            if (abandon) begin
                if (retry_ok) begin
                    retry_q <= retry_q + 4'd1;
                end else begin
                    tmo_err_q <= 1'b1;
                end
            end

            if (capture && (state_q == ID_WAIT)) begin
                id_word_q <= avm_readdata;
            end
            if (capture && (state_q == TS_WAIT)) begin
                ts_word_q <= avm_readdata;
            end

            if (state_q == CHECK) begin
                id_ok_q <= (id_word_q == EXPECTED_ID);
                ts_ok_q <= (ts_word_q == EXPECTED_TS);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign avm_read    = read_c;
    assign avm_address = addr_q;
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout_err = tmo_err_q;
    assign id_word     = id_word_q;
    assign ts_word     = ts_word_q;
    assign retry_count = retry_q;

endmodule
